// File: rtl/ptw_mem_responder.sv
// Memory-side responder for the SV39 page-table-walker read bus: local 64-bit RAM,
// fixed-latency reads with one pending slot, address error flagging, byte-strobed writes.
module ptw_mem_responder #(
    parameter int          DEPTH     = 512,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_addr,
    input  logic        bus_read,
    output logic [63:0] bus_rdata,
    output logic        bus_ready,
    output logic        bus_err,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] rd_count
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam state_t ST_START = (LATENCY == 1) ? ST_RESP : ST_WAIT;

    function automatic logic addr_ok(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE_ADDR;
        return (a[2:0] == 3'd0) && (a >= BASE_ADDR) && ((off >> 3) < 64'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [63:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                                input logic [63:0] new_w,
                                                input logic [7:0]  strb);
        logic [63:0] m;
        m = old_w;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                m[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                m[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return m;
    endfunction

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr;
    logic        r_pend_v;
    logic [63:0] r_pend_addr;
    logic        r_bus_ready;
    logic        r_bus_err;
    logic [63:0] r_bus_rdata;
    logic        r_busy;
    logic        r_overflow;
    logic [31:0] r_rd_count;
    logic [63:0] r_mem [DEPTH];

    state_t      w_state_next;
    logic [3:0]  w_cnt_next;
    logic [63:0] w_addr_next;
    logic        w_pend_v_next;
    logic [63:0] w_pend_addr_next;
    logic        w_drop;
    logic        w_wr_ok;
    logic [IDX_W-1:0] w_wr_idx;
    logic        w_rd_ok;
    logic [IDX_W-1:0] w_rd_idx;
    logic [63:0] w_rd_word;

    // Next-state, request capture and pending-slot management.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_addr_next      = r_addr;
        w_pend_v_next    = r_pend_v;
        w_pend_addr_next = r_pend_addr;
        w_drop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_read) begin
                    w_addr_next  = bus_addr;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
                if (bus_read) begin
                    if (r_pend_v) begin
                        w_drop = 1'b1;
                    end else begin
                        w_pend_v_next    = 1'b1;
                        w_pend_addr_next = bus_addr;
                    end
                end else begin
                    w_drop = 1'b0;
                end
            end
            ST_RESP: begin
                // The slot is served first, so a new request can always refill it.
                if (r_pend_v) begin
                    w_addr_next  = r_pend_addr;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = ST_START;
                    if (bus_read) begin
                        w_pend_v_next    = 1'b1;
                        w_pend_addr_next = bus_addr;
                    end else begin
                        w_pend_v_next = 1'b0;
                    end
                end else if (bus_read) begin
                    w_addr_next  = bus_addr;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // RAM read for the response being loaded, forwarding a same-edge write.
    always_comb begin
        w_wr_ok   = wr_en && addr_ok(wr_addr);
        w_wr_idx  = addr_idx(wr_addr);
        w_rd_ok   = addr_ok(w_addr_next);
        w_rd_idx  = addr_idx(w_addr_next);
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_ok && (w_wr_idx == w_rd_idx)) begin
            w_rd_word = merge_bytes(r_mem[w_rd_idx], wr_data, wr_strb);
        end else begin
            w_rd_word = r_mem[w_rd_idx];
        end
    end

    // FSM and request-tracking registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 64'd0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 64'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_addr      <= w_addr_next;
            r_pend_v    <= w_pend_v_next;
            r_pend_addr <= w_pend_addr_next;
        end
    end

    // Registered bus outputs; response data is captured on entry to RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_ready <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_rdata <= 64'd0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_count  <= 32'd0;
        end else begin
            r_bus_ready <= (w_state_next == ST_RESP);
            r_busy      <= (w_state_next == ST_WAIT);
            r_overflow  <= r_overflow | w_drop;
            if (w_state_next == ST_RESP) begin
                r_bus_err   <= ~w_rd_ok;
                r_bus_rdata <= w_rd_ok ? w_rd_word : 64'd0;
                r_rd_count  <= r_rd_count + 32'd1;
            end else begin
                r_bus_err <= 1'b0;
            end
        end
    end

    // Byte-masked RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx] <= merge_bytes(r_mem[w_wr_idx], wr_data, wr_strb);
        end
    end

    assign bus_rdata = r_bus_rdata;
    assign bus_ready = r_bus_ready;
    assign bus_err   = r_bus_err;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
    assign rd_count  = r_rd_count;

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Bench for ptw_mem_responder: LATENCY=1 and LATENCY=3 instances share stimulus and are
// checked every cycle against a transaction-level model (issue times, slot, word array).
module tb_ptw_mem_responder;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] bus_addr;
    logic        bus_read;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;

    logic [63:0] rdata_o [2];
    logic        ready_o [2];
    logic        err_o   [2];
    logic        busy_o  [2];
    logic        ovf_o   [2];
    logic [31:0] cnt_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ptw_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_read(bus_read),
        .bus_rdata(rdata_o[0]), .bus_ready(ready_o[0]), .bus_err(err_o[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .busy(busy_o[0]), .overflow(ovf_o[0]), .rd_count(cnt_o[0])
    );

    ptw_mem_responder #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_read(bus_read),
        .bus_rdata(rdata_o[1]), .bus_ready(ready_o[1]), .bus_err(err_o[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .busy(busy_o[1]), .overflow(ovf_o[1]), .rd_count(cnt_o[1])
    );

    // Reference model state
    int          lat [2] = '{1, 3};
    logic [63:0] m_mem [512];
    bit          m_inflight [2];
    longint      m_done [2];
    logic [63:0] m_addr [2];
    bit          m_pv [2];
    logic [63:0] m_paddr [2];
    bit          m_ovf [2];
    logic [31:0] m_cnt [2];
    logic [63:0] m_data [2];
    bit          m_ready [2];
    bit          m_err [2];
    bit          m_busy [2];
    longint      cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_ok(input logic [63:0] a);
        return (a % 64'd8 == 64'd0) && (a >= BASE) && ((a - BASE) / 64'd8 < 64'd512);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_inflight[i] = 1'b0;
            m_pv[i]       = 1'b0;
            m_ovf[i]      = 1'b0;
            m_cnt[i]      = 32'd0;
            m_data[i]     = 64'd0;
        end
    endtask

    task automatic check_all(input int i);
        string p;
        p = $sformatf("L%0d_", lat[i]);
        check_eq({p, "ready"}, 64'(ready_o[i]), 64'(m_ready[i]));
        check_eq({p, "err"},   64'(err_o[i]),   64'(m_err[i]));
        check_eq({p, "rdata"}, rdata_o[i],      m_data[i]);
        check_eq({p, "busy"},  64'(busy_o[i]),  64'(m_busy[i]));
        check_eq({p, "ovf"},   64'(ovf_o[i]),   64'(m_ovf[i]));
        check_eq({p, "count"}, 64'(cnt_o[i]),   64'(m_cnt[i]));
    endtask

    task automatic do_cycle(input logic rd, input logic [63:0] ra, input logic we,
                            input logic [63:0] wa, input logic [63:0] wd, input logic [7:0] ws);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = m_inflight[i] && (m_done[i] == cyc);
            m_busy[i]  = m_inflight[i] && (m_done[i] > cyc) && (m_done[i] - longint'(lat[i]) < cyc);
            m_err[i]   = 1'b0;
            if (m_ready[i]) begin
                m_err[i]  = !model_ok(m_addr[i]);
                m_data[i] = m_err[i] ? 64'd0 : m_mem[(m_addr[i] - BASE) / 64'd8];
                m_cnt[i]  = m_cnt[i] + 32'd1;
                if (m_pv[i]) begin
                    m_addr[i] = m_paddr[i];
                    m_done[i] = cyc + longint'(lat[i]);
                    m_pv[i]   = 1'b0;
                end else begin
                    m_inflight[i] = 1'b0;
                end
            end
            check_all(i);
        end
        bus_read = rd; bus_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
        for (int i = 0; i < 2; i++) begin
            if (rd) begin
                if (!m_inflight[i]) begin
                    m_inflight[i] = 1'b1;
                    m_addr[i]     = ra;
                    m_done[i]     = cyc + longint'(lat[i]);
                end else if (!m_pv[i]) begin
                    m_pv[i]    = 1'b1;
                    m_paddr[i] = ra;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
        if (we && model_ok(wa)) begin
            for (int b = 0; b < 8; b++) begin
                if (ws[b]) m_mem[(wa - BASE) / 64'd8][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic rd(input logic [63:0] a);
        do_cycle(1'b1, a, 1'b0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        do_cycle(1'b0, 64'd0, 1'b1, a, d, s);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bus_read = 1'b0; wr_en = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_ready", 64'(ready_o[i]), 64'd0);
            check_eq("rst_err",   64'(err_o[i]),   64'd0);
            check_eq("rst_rdata", rdata_o[i],      64'd0);
            check_eq("rst_busy",  64'(busy_o[i]),  64'd0);
            check_eq("rst_ovf",   64'(ovf_o[i]),   64'd0);
            check_eq("rst_count", 64'(cnt_o[i]),   64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] w;
        reset = 1'b0; bus_read = 1'b0; bus_addr = 64'd0;
        wr_en = 1'b0; wr_addr = 64'd0; wr_data = 64'd0; wr_strb = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) wr(BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);

        // Basic read with LATENCY=1
        wr(BASE + 64'd8, 64'h0000_0000_2000_0401, 8'hFF);
        rd(BASE + 64'd8);
        idle(1);
        check_eq("basic_ready", 64'(ready_o[0]), 64'd1);
        check_eq("basic_rdata", rdata_o[0], 64'h0000_0000_2000_0401);
        check_eq("basic_err",   64'(err_o[0]), 64'd0);
        check_eq("basic_count", 64'(cnt_o[0]), 64'd1);
        idle(3);

        // Error addresses: misaligned, past the end, below base
        for (int j = 0; j < 3; j++) begin
            a = (j == 0) ? 64'h8000_0004 : (j == 1) ? 64'h8000_1000 : 64'h7FFF_FFF8;
            rd(a);
            idle(1);
            check_eq("err_flag",  64'(err_o[0]), 64'd1);
            check_eq("err_rdata", rdata_o[0], 64'd0);
            check_eq("err_count", 64'(cnt_o[0]), 64'(j + 2));
            idle(3);
        end

        // Byte strobes, including an all-zero strobe
        wr(BASE + 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(BASE + 64'd16, 64'd0, 8'h0F);
        wr(BASE + 64'd16, 64'd0, 8'h00);
        rd(BASE + 64'd16);
        idle(1);
        check_eq("strb_rdata", rdata_o[0], 64'hFFFF_FFFF_0000_0000);
        idle(3);

        // Same-cycle hazard on word 5
        wr(BASE + 64'd40, 64'h1234, 8'hFF);
        idle(1);
        rd(BASE + 64'd40);
        do_cycle(1'b0, 64'd0, 1'b1, BASE + 64'd40, 64'hA5, 8'hFF);
        check_eq("haz_old", rdata_o[0], 64'h1234);
        idle(3);
        rd(BASE + 64'd40);
        idle(1);
        check_eq("haz_new", rdata_o[0], 64'hA5);
        idle(3);

        // Queueing with LATENCY=3: responses 3 and 6 cycles after the first request
        rd(BASE + 64'd8);
        rd(BASE + 64'd16);
        rd(BASE + 64'd24);
        idle(1);
        check_eq("q_ready1", 64'(ready_o[1]), 64'd1);
        check_eq("q_rdata1", rdata_o[1], 64'h0000_0000_2000_0401);
        idle(2);
        check_eq("q_ready_gap", 64'(ready_o[1]), 64'd0);
        idle(1);
        check_eq("q_ready2", 64'(ready_o[1]), 64'd1);
        check_eq("q_rdata2", rdata_o[1], 64'hFFFF_FFFF_0000_0000);
        idle(5);
        check_eq("q_ovf_l3", 64'(ovf_o[1]), 64'd1);
        check_eq("q_ovf_l1", 64'(ovf_o[0]), 64'd0);

        // Reset in the middle of a LATENCY=3 wait
        rd(BASE + 64'd8);
        idle(1);
        check_eq("mid_busy", 64'(busy_o[1]), 64'd1);
        apply_reset();
        idle(5);
        rd(BASE + 64'd8);
        idle(4);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) apply_reset();
            case ($urandom_range(0, 9))
                0:       a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(1, 7));
                1:       a = BASE + 64'(8 * (512 + $urandom_range(0, 15)));
                2:       a = BASE - 64'(8 * $urandom_range(1, 4));
                default: a = BASE + 64'(8 * $urandom_range(0, 15));
            endcase
            w = ($urandom_range(0, 7) == 0) ? BASE + 64'd3 : BASE + 64'(8 * $urandom_range(0, 15));
            do_cycle(($urandom_range(0, 2) == 0), a, ($urandom_range(0, 3) == 0), w,
                     {$urandom, $urandom}, 8'($urandom));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
